rssb_loader: RTL and testbench
==============================

# rssb_loader

Program loader sitting directly upstream of the RSSB core and its data memory. Before execution it receives a framed program image over a valid/ready word stream and writes it into data memory from address 0. It checks a modular checksum and holds the core in reset until a verified image is resident. The core then runs from PC = 0 on the loaded image.

## Interface
Parameters:
- WIDTH, 8, data and address width; must match core WIDTH.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE, RUN, ERROR.
- in_data  input  WIDTH  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- mem_write  output  1  data-memory write strobe, one cycle per word.
- mem_address  output  WIDTH  write address.
- mem_data  output  WIDTH  write data.
- core_rst  output  1  held high to keep the core in reset; low only in RUN.
- busy  output  1  load in progress (LEN, DATA, CHECK).
- done  output  1  verified image loaded; core running.
- error  output  1  last load rejected.

## Operation
- Frame format: the length word N, then N image words, then one checksum word C.
- Accepted values: 1 ≤ N ≤ 2^WIDTH−1. Image word i is written to address i.
- Acceptance test: the sum of all image words plus C, taken mod 2^WIDTH, must equal 0.
- Handshake: a word transfers on a rising edge with in_valid && in_ready. in_valid may drop at any time; in_data is ignored without a handshake.
- FSM states: IDLE, LEN, DATA, CHECK, RUN, ERROR.
  - IDLE: waits for start, then goes to LEN.
  - LEN: on handshake, latches N and clears count and sum.
    - N = 0 goes to ERROR.
    - Any other N goes to DATA.
  - DATA: on handshake, writes in_data to address count. The sum accumulates mod 2^WIDTH and count increments.
    - The handshake with count = N−1 goes to CHECK.
  - CHECK: on handshake, tests sum + in_data mod 2^WIDTH.
    - Result 0 goes to RUN.
    - Any other result goes to ERROR.
  - RUN: start goes to LEN. This reloads and puts the core back into reset.
  - ERROR: start goes to LEN.
- Moore outputs, decoded from the state register:
  - in_ready = LEN | DATA | CHECK.
  - busy is the same set of states as in_ready.
  - core_rst = !RUN.
  - done = RUN.
  - error = ERROR.
- start is ignored in LEN, DATA and CHECK.
- Memory words outside 0..N−1 are never written. Contents from earlier loads persist.
- rst at any point, including mid-frame:
  - FSM returns to IDLE.
  - core_rst = 1; in_ready, mem_write, busy, done and error = 0.
  - mem_address = 0, mem_data = 0.
  - Words already written stay in memory.
  - The next load needs a new start and a complete frame.

## Timing
- Reset values: core_rst 1, every other output 0.
- mem_write, mem_address and mem_data are registered. The strobe is high for exactly the one cycle following each DATA handshake. Otherwise mem_write = 0, and address and data hold their last values.
- Throughput: one word per cycle while in_valid is held high.
- Load latency: a frame of N words with no stall takes N+2 handshake cycles after LEN is entered.
- The state change is visible the cycle after the handshake edge:
  - CHECK→RUN: done = 1 and core_rst = 0.
  - CHECK→ERROR: error = 1.
- The last image write occurs during the first CHECK cycle. A CHECK handshake in that same cycle is legal, because the memory write completes on that edge.
- start→LEN: in_ready and core_rst are high the cycle after start is sampled.
- Count and sum arithmetic wrap mod 2^WIDTH. The count never exceeds N−1.

## Structure
- Shared package rssb_pkg:
  - typedef enum logic [2:0] loader_state_t for the six states.
  - The default width constant, shared with the core.
- One module. The count, sum and length registers are inline.
- The address increment reuses the existing inc module.

## Test plan
- Good frame: start, then 0x03, 0x10, 0x20, 0x30, 0xA0 with in_valid continuously high.
  - Writes (0,0x10), (1,0x20), (2,0x30) on consecutive cycles.
  - done = 1 and core_rst = 0 the cycle after the 0xA0 handshake.
- Bad checksum: same frame with 0xA1 as the last word.
  - Same three writes.
  - error = 1, core_rst stays 1, done = 0.
  - A following start gives busy = 1 and error = 0.
- Zero length: start, then 0x00.
  - No mem_write.
  - error = 1 the cycle after the handshake.
- Backpressure and gaps: the good frame with in_valid toggling 1,0,0,1…
  - Writes only on handshakes, addresses 0, 1, 2 with no duplicates.
  - A start pulsed during DATA has no effect.
- Reset mid-frame: rst after the second image word.
  - The next cycle shows IDLE outputs: core_rst 1, in_ready 0.
  - A new full frame with N = 1, 0x05, checksum 0xFB reaches RUN and writes address 0 only.
- Max length and reload: a frame of N = 255 words with value 0x01 and checksum 0x01.
  - Writes addresses 0..254; the sum wraps and the frame is accepted.
  - start in RUN reasserts core_rst the next cycle.

Source files
------------

// File: rtl/rssb_pkg.sv
// Shared RSSB definitions: default datapath width and the program loader state encoding.
package rssb_pkg;

    localparam int unsigned RSSB_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/rssb_loader_inc.sv
// Wrapping incrementer shared by the RSSB core and loader address/count paths.
module inc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = value + WIDTH'(1);

endmodule

// File: rtl/rssb_loader.sv
// Program loader: receives a length/image/checksum frame, writes the image to data memory
// from address 0 and releases the RSSB core from reset only after the checksum verifies.
module rssb_loader
    import rssb_pkg::*;
#(
    parameter int unsigned WIDTH = RSSB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_data,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t    state, state_next;
    logic [WIDTH-1:0] len;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] check_total;
    logic [WIDTH-1:0] len_last;
    logic             handshake;

    inc #(.WIDTH(WIDTH)) u_inc (
        .value  (count),
        .result (count_inc)
    );

    assign handshake   = in_valid && in_ready;
    assign check_total = sum + in_data;
    assign len_last    = len - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            len         <= '0;
            count       <= '0;
            sum         <= '0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            state     <= state_next;
            mem_write <= 1'b0;
            if (handshake && state == S_LEN) begin
                len   <= in_data;
                count <= '0;
                sum   <= '0;
            end
            if (handshake && state == S_DATA) begin
                mem_write   <= 1'b1;
                mem_address <= count;
                mem_data    <= in_data;
                sum         <= sum + in_data;
                // Hold at N-1 so the count never runs past the last image address.
                if (count != len_last) begin
                    count <= count_inc;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_rst   = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (handshake) state_next = (in_data == '0) ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (handshake && count == len_last) state_next = S_CHECK;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (handshake) state_next = (check_total == '0) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) state_next = S_LEN;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rssb_loader.sv
module tb_rssb_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       core_rst;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int fails  = 0;
  logic [15:0] exp_q[$];

  rssb_loader #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({in_ready, core_rst, busy} !== 3'b111) begin
      fails++;
      $display("FAIL start_to_len: ready/core_rst/busy=%b expected 111", {in_ready, core_rst, busy});
    end
  endtask

  task automatic send(input logic [7:0] d, input bit is_data, input logic [7:0] addr);
    bit got;
    logic [15:0] exp;
    if (is_data) exp_q.push_back({addr, d});
    in_data  = d;
    in_valid = 1'b1;
    got = 1'b0;
    for (int unsigned i = 0; i < 64 && !got; i++) begin
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL handshake_timeout: word %h never accepted", d);
    end
    if (is_data) begin
      exp = exp_q.pop_front();
      checks++;
      if ({mem_write, mem_address, mem_data} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL mem_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 mem_write, mem_address, mem_data, exp[15:8], exp[7:0]);
      end
    end else begin
      checks++;
      if (mem_write !== 1'b0) begin
        fails++;
        $display("FAIL stray_write: mem_write=%b expected 0 after word %h", mem_write, d);
      end
    end
  endtask

  task automatic gap(input int unsigned n);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_write !== 1'b0) begin
        fails++;
        $display("FAIL gap_write: mem_write=%b expected 0", mem_write);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({core_rst, in_ready, mem_write, busy, done, error, mem_address, mem_data} !== {6'b100000, 16'h0000}) begin
      fails++;
      $display("FAIL reset_state: outputs=%b_%h_%h expected 100000_00_00",
               {core_rst, in_ready, mem_write, busy, done, error}, mem_address, mem_data);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    do_start();
    send(8'h03, 0, 8'h00);
    send(8'h10, 1, 8'h00);
    send(8'h20, 1, 8'h01);
    send(8'h30, 1, 8'h02);
    send(8'hA0, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({done, core_rst, error, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL good_run: done/core_rst/error/busy=%b expected 1000", {done, core_rst, error, busy});
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    do_start();
    send(8'h03, 0, 8'h00);
    send(8'h10, 1, 8'h00);
    send(8'h20, 1, 8'h01);
    send(8'h30, 1, 8'h02);
    send(8'hA1, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({error, core_rst, done} !== 3'b110) begin
      fails++;
      $display("FAIL bad_checksum: error/core_rst/done=%b expected 110", {error, core_rst, done});
    end
    do_start();
    checks++;
    if ({busy, error} !== 2'b10) begin
      fails++;
      $display("FAIL restart_after_error: busy/error=%b expected 10", {busy, error});
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    do_start();
    send(8'h00, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({error, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL zero_length: error/busy/done=%b expected 100", {error, busy, done});
    end
    gap(2);
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    send(8'h03, 0, 8'h00);
    gap(2);
    send(8'h10, 1, 8'h00);
    gap(1);
    start = 1'b1;
    gap(1);
    start = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL start_ignored: busy/in_ready=%b expected 11", {busy, in_ready});
    end
    send(8'h20, 1, 8'h01);
    gap(2);
    send(8'h30, 1, 8'h02);
    gap(2);
    send(8'hA0, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({done, core_rst} !== 2'b10) begin
      fails++;
      $display("FAIL gapped_run: done/core_rst=%b expected 10", {done, core_rst});
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    do_start();
    send(8'h03, 0, 8'h00);
    send(8'h10, 1, 8'h00);
    send(8'h20, 1, 8'h01);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({core_rst, in_ready, busy, mem_write, mem_address, mem_data} !== {4'b1000, 16'h0000}) begin
      fails++;
      $display("FAIL mid_reset: outputs=%b_%h_%h expected 1000_00_00",
               {core_rst, in_ready, busy, mem_write}, mem_address, mem_data);
    end
    do_start();
    send(8'h01, 0, 8'h00);
    send(8'h05, 1, 8'h00);
    send(8'hFB, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({done, core_rst} !== 2'b10) begin
      fails++;
      $display("FAIL reload_run: done/core_rst=%b expected 10", {done, core_rst});
    end
    gap(2);
  endtask

  task automatic test_max_length();
    do_reset();
    do_start();
    send(8'hFF, 0, 8'h00);
    for (int unsigned i = 0; i < 255; i++) send(8'h01, 1, 8'(i));
    send(8'h01, 0, 8'h00);
    in_valid = 1'b0;
    checks++;
    if ({done, core_rst, error} !== 3'b100) begin
      fails++;
      $display("FAIL max_length_run: done/core_rst/error=%b expected 100", {done, core_rst, error});
    end
    do_start();
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL run_reload: done=%b expected 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_length();
    test_backpressure();
    test_reset_mid_frame();
    test_max_length();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d writes outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
